phase_sequencer: RTL and testbench
==================================

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameter N_PHASES, default 4, number of signal phases (2..8).
REQ-002 Parameter TICKS_PER_SEC, default 10000, clk cycles per one-second tick.
REQ-003 Parameter T_GREEN_MIN, default 10, minimum green seconds.
REQ-004 Parameter T_GREEN_MAX, default 30, maximum green seconds once a conflicting demand is latched.
REQ-005 Parameter T_YELLOW, default 3, yellow seconds.
REQ-006 Parameter T_ALLRED, default 2, all-red clearance seconds.
REQ-007 Parameter SKIP_EMPTY, default 1; 1 skips phases with no latched demand, 0 serves phases in strict rotation.
REQ-008 clk  input  1  system clock (10 kHz LFOSC).
REQ-009 reset  input  1  asynchronous, active-high reset.
REQ-010 enable  input  1  1 = normal sequencing, 0 = flashing-yellow mode.
REQ-011 demand  input  N_PHASES  per-phase vehicle/pedestrian sensor, level, synchronous to clk.
REQ-012 light  output  2*N_PHASES  per-phase light code, phase i at bits [2i+1:2i].
REQ-013 phase  output  clog2(N_PHASES)  index of the phase currently green, yellow or last cleared.
REQ-014 phase_start  output  1  one-cycle pulse on the cycle a phase enters GREEN.

Function
REQ-015 Light codes: 00 off, 01 green, 10 yellow, 11 red.
REQ-016 Prescaler counts 0..TICKS_PER_SEC-1 and issues a one-cycle tick on wrap; all durations count ticks.
REQ-017 States: FLASH, ALL_RED, GREEN, YELLOW; the second counter clears on every state entry.
REQ-018 ALL_RED: all channels 11; after T_ALLRED ticks, next phase (REQ-022) enters GREEN, phase_start=1, its demand latch cleared.
REQ-019 GREEN: current phase channel 01, others 11; leave to YELLOW when count>=T_GREEN_MIN AND another phase's latch is set AND (own demand=0 OR count>=T_GREEN_MAX).
REQ-020 No conflicting demand: GREEN rests indefinitely; counter saturates at T_GREEN_MAX.
REQ-021 YELLOW: current channel 10, others 11; after T_YELLOW ticks go to ALL_RED.
REQ-022 Next phase: SKIP_EMPTY=1 -> first index after current (mod N_PHASES) with latch set; none set -> current+1; SKIP_EMPTY=0 -> current+1 mod N_PHASES.
REQ-023 Demand latch bit i sets when demand[i]=1 and phase i is not GREEN; clears on phase i GREEN entry; set and clear same cycle -> clear wins.
REQ-024 enable=0 in any state: FLASH next cycle; all channels toggle 10/00 each tick, starting 10.
REQ-025 enable 0->1: FLASH -> ALL_RED with phase forced so next phase is 0 (phase = N_PHASES-1).
REQ-026 State transitions occur on the tick cycle; light and phase are registered and change together one cycle after the decision.
REQ-027 phase_start never asserts in FLASH; only one phase is ever non-red outside FLASH.

Reset
REQ-028 On reset: state ALL_RED, phase=N_PHASES-1, light all 11, phase_start=0, prescaler, second counter and demand latches 0.
REQ-029 Reset asserted mid-GREEN or mid-YELLOW forces all-red on the same edge (asynchronous); first green after release is phase 0 after T_ALLRED ticks.

Structure
REQ-030 Shared package holds light-code constants, state enumeration and the clog2 width helper.
REQ-031 The prescaler is a separate sub-module tick_gen (parameter TICKS_PER_SEC, outputs tick).

Verification (TICKS_PER_SEC=4, N_PHASES=4, T_GREEN_MIN=2, T_GREEN_MAX=4, T_YELLOW=1, T_ALLRED=1)
REQ-032 Release reset, no demand -> phase 0 green after 4 clk (+1), rests green, phase_start pulses once.
REQ-033 Phase 0 green, demand=0100 pulse -> green ends at 2 s, 1 s yellow, 1 s all-red, phase=2 green (1 skipped).
REQ-034 Phase 0 green, demand[0] held high, demand[3] latched -> green held to 4 s, then phase 3.
REQ-035 SKIP_EMPTY=0, demand all 1 -> phases 0,1,2,3,0 in order, each green exactly 4 s.
REQ-036 enable low mid-GREEN -> all channels 10/00 alternate every 4 clk; enable high -> 1 s all-red then phase 0 green.
REQ-037 reset pulse during YELLOW -> light=all 11 immediately, latches cleared, restart per REQ-029.

Source files
------------

// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the phase sequencer: light codes, controller states
// and a width helper used to size counters and phase indices.
package phase_sequencer_pkg;

  localparam logic [1:0] LIGHT_OFF    = 2'b00;
  localparam logic [1:0] LIGHT_GREEN  = 2'b01;
  localparam logic [1:0] LIGHT_YELLOW = 2'b10;
  localparam logic [1:0] LIGHT_RED    = 2'b11;

  localparam logic [1:0] ST_FLASH   = 2'd0;
  localparam logic [1:0] ST_ALL_RED = 2'd1;
  localparam logic [1:0] ST_GREEN   = 2'd2;
  localparam logic [1:0] ST_YELLOW  = 2'd3;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int clog2w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/phase_sequencer_tick_gen.sv
// One-second prescaler: counts clock cycles and flags the last cycle of each
// second so the controller can advance its timers.
module tick_gen
  import phase_sequencer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 10000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = clog2w(TICKS_PER_SEC);
  localparam logic [CW-1:0] C_LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (r_count == C_LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign tick = (r_count == C_LAST);

endmodule

// File: rtl/phase_sequencer.sv
// Traffic-signal phase controller: serves one phase at a time through
// green/yellow/all-red, latching demand for waiting phases, with a flashing fallback.
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int N_PHASES      = 4,
  parameter int TICKS_PER_SEC = 10000,
  parameter int T_GREEN_MIN   = 10,
  parameter int T_GREEN_MAX   = 30,
  parameter int T_YELLOW      = 3,
  parameter int T_ALLRED      = 2,
  parameter int SKIP_EMPTY    = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [N_PHASES-1:0]           demand,
  output logic [2*N_PHASES-1:0]         light,
  output logic [clog2w(N_PHASES)-1:0]   phase,
  output logic                          phase_start
);

  localparam int PW = clog2w(N_PHASES);
  localparam int SW = clog2w(T_GREEN_MAX + T_GREEN_MIN + T_YELLOW + T_ALLRED + 2);
  localparam logic [PW-1:0] C_LASTPH = PW'(N_PHASES - 1);
  localparam logic [SW-1:0] C_GMIN   = SW'(T_GREEN_MIN);
  localparam logic [SW-1:0] C_GMAX   = SW'(T_GREEN_MAX);
  localparam logic [SW-1:0] C_YEL    = SW'(T_YELLOW);
  localparam logic [SW-1:0] C_AR     = SW'(T_ALLRED);

  logic [1:0]            r_state, w_stateNext;
  logic [PW-1:0]         r_phase, w_phaseNext, w_nextPhase;
  logic [SW-1:0]         r_sec, w_secNext, w_elapsed;
  logic [N_PHASES-1:0]   r_latch, w_latchNext, w_curMask, w_nextMask, w_greenMask, w_others;
  logic                  r_flash, w_flashNext, r_start, w_enterGreen, w_tick;
  logic [2*N_PHASES-1:0] r_light, w_lightNext;

  tick_gen #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  assign w_elapsed = r_sec + 1'b1;

  // Candidate for the next green: first latched phase after the current one,
  // otherwise plain rotation.
  always_comb begin
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    w_nextPhase = (r_phase == C_LASTPH) ? '0 : r_phase + 1'b1;
    if (SKIP_EMPTY != 0) begin
      for (int k = 1; k < N_PHASES; k++) begin
        idx = (int'(r_phase) + k) % N_PHASES;
        if (!found && r_latch[idx]) begin
          w_nextPhase = PW'(idx);
          found       = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_curMask          = '0;
    w_curMask[r_phase] = 1'b1;
    w_others           = r_latch & ~w_curMask;
  end

  always_comb begin
    w_stateNext = r_state;
    w_phaseNext = r_phase;
    w_secNext   = r_sec;
    w_flashNext = r_flash;
    if (!enable) begin
      w_stateNext = ST_FLASH;
      if (r_state != ST_FLASH) begin
        w_secNext   = '0;
        w_flashNext = 1'b1;
      end else if (w_tick) begin
        w_flashNext = ~r_flash;
      end
    end else begin
      case (r_state)
        ST_FLASH: begin
          w_stateNext = ST_ALL_RED;
          w_phaseNext = C_LASTPH;
          w_secNext   = '0;
        end
        ST_ALL_RED: if (w_tick) begin
          if (w_elapsed >= C_AR) begin
            w_stateNext = ST_GREEN;
            w_phaseNext = w_nextPhase;
            w_secNext   = '0;
          end else begin
            w_secNext = w_elapsed;
          end
        end
        ST_GREEN: if (w_tick) begin
          if (w_elapsed >= C_GMIN && (|w_others) &&
              (!demand[r_phase] || w_elapsed >= C_GMAX)) begin
            w_stateNext = ST_YELLOW;
            w_secNext   = '0;
          end else begin
            w_secNext = (w_elapsed >= C_GMAX) ? C_GMAX : w_elapsed;
          end
        end
        default: if (w_tick) begin
          if (w_elapsed >= C_YEL) begin
            w_stateNext = ST_ALL_RED;
            w_secNext   = '0;
          end else begin
            w_secNext = w_elapsed;
          end
        end
      endcase
    end
  end

  // A phase's own latch is cleared as it turns green, overriding a same-cycle set.
  always_comb begin
    w_enterGreen            = (w_stateNext == ST_GREEN) && (r_state != ST_GREEN);
    w_nextMask              = '0;
    w_nextMask[w_phaseNext] = 1'b1;
    w_greenMask             = (r_state == ST_GREEN) ? w_curMask : '0;
    w_latchNext             = (r_latch | (demand & ~w_greenMask)) &
                              ~(w_enterGreen ? w_nextMask : '0);
  end

  always_comb begin
    w_lightNext = '1;
    for (int i = 0; i < N_PHASES; i++) begin
      case (w_stateNext)
        ST_FLASH:  w_lightNext[2*i +: 2] = w_flashNext ? LIGHT_YELLOW : LIGHT_OFF;
        ST_GREEN:  if (PW'(i) == w_phaseNext) w_lightNext[2*i +: 2] = LIGHT_GREEN;
        ST_YELLOW: if (PW'(i) == w_phaseNext) w_lightNext[2*i +: 2] = LIGHT_YELLOW;
        default:   w_lightNext[2*i +: 2] = LIGHT_RED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_ALL_RED;
      r_phase <= C_LASTPH;
      r_sec   <= '0;
      r_latch <= '0;
      r_flash <= 1'b0;
      r_light <= {N_PHASES{LIGHT_RED}};
      r_start <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_phase <= w_phaseNext;
      r_sec   <= w_secNext;
      r_latch <= w_latchNext;
      r_flash <= w_flashNext;
      r_light <= w_lightNext;
      r_start <= w_enterGreen;
    end
  end

  assign light       = r_light;
  assign phase       = r_phase;
  assign phase_start = r_start;

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: directed scenarios with hand-derived
// timing plus a randomized run against a seconds-level behavioural model.
module tb_phase_sequencer;

  localparam int N = 4, TPS = 4, GMIN = 2, GMAX = 4, TYEL = 1, TAR = 1;
  localparam int M_FLASH = 0, M_CLEAR = 1, M_GREEN = 2, M_YELLOW = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1, enRot = 1'b1;
  logic [3:0] dem = '0, demRot = '0;
  logic [7:0] light, lightRot;
  logic [1:0] phase, phaseRot;
  logic       start, startRot;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  phase_sequencer #(.N_PHASES(N), .TICKS_PER_SEC(TPS), .T_GREEN_MIN(GMIN), .T_GREEN_MAX(GMAX),
                    .T_YELLOW(TYEL), .T_ALLRED(TAR), .SKIP_EMPTY(1)) dut (
    .clk(clk), .reset(rst), .enable(en), .demand(dem),
    .light(light), .phase(phase), .phase_start(start));

  phase_sequencer #(.N_PHASES(N), .TICKS_PER_SEC(TPS), .T_GREEN_MIN(GMIN), .T_GREEN_MAX(GMAX),
                    .T_YELLOW(TYEL), .T_ALLRED(TAR), .SKIP_EMPTY(0)) dutRot (
    .clk(clk), .reset(rst), .enable(enRot), .demand(demRot),
    .light(lightRot), .phase(phaseRot), .phase_start(startRot));

  // All red except phase p, which shows code.
  function automatic logic [7:0] oneLit(int p, logic [1:0] code);
    logic [7:0] v;
    v = 8'hFF;
    v[2*p +: 2] = code;
    return v;
  endfunction

  // Behavioural model of the skip-empty instance, tracked in whole seconds.
  int         mPre, mMode, mSecs, mPh;
  logic [3:0] mPend;
  logic       mLit, mStart;
  logic [7:0] mLight;

  function automatic int pickNext(int cur, logic [3:0] pend);
    for (int k = 1; k < N; k++) if (pend[(cur + k) % N]) return (cur + k) % N;
    return (cur + 1) % N;
  endfunction

  task automatic modelStep();
    logic tick;
    logic [3:0] oldPend, others;
    tick = (mPre == TPS - 1);
    mPre = tick ? 0 : mPre + 1;
    oldPend = mPend;
    others = oldPend;
    others[mPh] = 1'b0;
    for (int i = 0; i < N; i++)
      if (dem[i] && !(mMode == M_GREEN && i == mPh)) mPend[i] = 1'b1;
    mStart = 1'b0;
    if (!en) begin
      if (mMode != M_FLASH) begin mMode = M_FLASH; mLit = 1'b1; mSecs = 0; end
      else if (tick) mLit = !mLit;
    end else if (mMode == M_FLASH) begin
      mMode = M_CLEAR; mPh = N - 1; mSecs = 0;
    end else if (tick) begin
      mSecs++;
      if (mMode == M_CLEAR && mSecs >= TAR) begin
        mMode = M_GREEN; mPh = pickNext(mPh, oldPend); mSecs = 0;
        mStart = 1'b1; mPend[mPh] = 1'b0;
      end else if (mMode == M_GREEN) begin
        if (mSecs >= GMIN && others != 0 && (!dem[mPh] || mSecs >= GMAX)) begin
          mMode = M_YELLOW; mSecs = 0;
        end else if (mSecs > GMAX) mSecs = GMAX;
      end else if (mMode == M_YELLOW && mSecs >= TYEL) begin
        mMode = M_CLEAR; mSecs = 0;
      end
    end
    case (mMode)
      M_FLASH: mLight = mLit ? 8'hAA : 8'h00;
      M_GREEN: mLight = oneLit(mPh, 2'b01);
      M_YELLOW: mLight = oneLit(mPh, 2'b10);
      default: mLight = 8'hFF;
    endcase
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mPre = 0; mMode = M_CLEAR; mSecs = 0; mPh = N - 1;
      mPend = '0; mLit = 1'b0; mStart = 1'b0; mLight = 8'hFF;
    end else begin
      modelStep();
    end
  end

  task automatic stepTo(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; dem = '0; en = 1'b1;
    stepTo(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    stepTo(2);
    checks++; if (light !== 8'hFF) begin failures++; $display("[TB] FAIL reset_light got=%h want=ff", light); end
    checks++; if (phase !== 2'd3) begin failures++; $display("[TB] FAIL reset_phase got=%0d want=3", phase); end
    checks++; if (start !== 1'b0) begin failures++; $display("[TB] FAIL reset_start got=%b want=0", start); end
    checks++; if (lightRot !== 8'hFF) begin failures++; $display("[TB] FAIL reset_light_rot got=%h want=ff", lightRot); end
  endtask

  task automatic test_first_green();
    int pulses;
    doReset();
    stepTo(3);
    checks++; if (light !== 8'hFF) begin failures++; $display("[TB] FAIL first_green_early got=%h want=ff", light); end
    stepTo(1);
    checks++; if (light !== 8'hFD || phase !== 2'd0) begin failures++; $display("[TB] FAIL first_green got=%h/%0d want=fd/0", light, phase); end
    checks++; if (start !== 1'b1) begin failures++; $display("[TB] FAIL first_green_start got=%b want=1", start); end
    pulses = 0;
    for (int c = 0; c < 20; c++) begin stepTo(1); if (start) pulses++; end
    checks++; if (pulses != 0 || light !== 8'hFD) begin failures++; $display("[TB] FAIL rest_green got pulses=%0d light=%h want 0/fd", pulses, light); end
  endtask

  task automatic test_skip_empty();
    doReset();
    stepTo(4);
    dem = 4'b0100;
    stepTo(1);
    dem = '0;
    stepTo(6);
    checks++; if (light !== 8'hFD) begin failures++; $display("[TB] FAIL skip_hold got=%h want=fd", light); end
    stepTo(1);
    checks++; if (light !== 8'hFE) begin failures++; $display("[TB] FAIL skip_yellow got=%h want=fe", light); end
    stepTo(4);
    checks++; if (light !== 8'hFF) begin failures++; $display("[TB] FAIL skip_allred got=%h want=ff", light); end
    stepTo(4);
    checks++; if (light !== 8'hDF || phase !== 2'd2 || start !== 1'b1) begin failures++; $display("[TB] FAIL skip_next got=%h/%0d/%b want=df/2/1", light, phase, start); end
  endtask

  task automatic test_green_max();
    doReset();
    stepTo(4);
    dem = 4'b1001;
    stepTo(1);
    dem = 4'b0001;
    stepTo(14);
    checks++; if (light !== 8'hFD) begin failures++; $display("[TB] FAIL max_hold got=%h want=fd", light); end
    stepTo(1);
    checks++; if (light !== 8'hFE) begin failures++; $display("[TB] FAIL max_yellow got=%h want=fe", light); end
    dem = '0;
    stepTo(8);
    checks++; if (light !== 8'h7F || phase !== 2'd3) begin failures++; $display("[TB] FAIL max_next got=%h/%0d want=7f/3", light, phase); end
  endtask

  task automatic test_rotation();
    demRot = 4'hF;
    doReset();
    stepTo(4);
    for (int k = 0; k <= 4; k++) begin
      checks++;
      if (phaseRot !== 2'(k % 4) || startRot !== 1'b1 || lightRot !== oneLit(k % 4, 2'b01)) begin
        failures++; $display("[TB] FAIL rot_entry%0d got=%h/%0d/%b want=%h/%0d/1", k, lightRot, phaseRot, startRot, oneLit(k % 4, 2'b01), k % 4);
      end
      if (k < 4) begin
        stepTo(15);
        checks++; if (lightRot !== oneLit(k, 2'b01)) begin failures++; $display("[TB] FAIL rot_green%0d got=%h want=%h", k, lightRot, oneLit(k, 2'b01)); end
        stepTo(1);
        checks++; if (lightRot !== oneLit(k, 2'b10)) begin failures++; $display("[TB] FAIL rot_yellow%0d got=%h want=%h", k, lightRot, oneLit(k, 2'b10)); end
        stepTo(8);
      end
    end
    demRot = '0;
  endtask

  task automatic test_flash();
    int pulses;
    doReset();
    stepTo(6);
    en = 1'b0;
    stepTo(1);
    checks++; if (light !== 8'hAA) begin failures++; $display("[TB] FAIL flash_enter got=%h want=aa", light); end
    pulses = 0;
    stepTo(1); if (start) pulses++;
    checks++; if (light !== 8'h00) begin failures++; $display("[TB] FAIL flash_off got=%h want=00", light); end
    stepTo(3); if (start) pulses++;
    checks++; if (light !== 8'h00) begin failures++; $display("[TB] FAIL flash_off_hold got=%h want=00", light); end
    stepTo(1); if (start) pulses++;
    checks++; if (light !== 8'hAA) begin failures++; $display("[TB] FAIL flash_on got=%h want=aa", light); end
    stepTo(4); if (start) pulses++;
    checks++; if (pulses != 0) begin failures++; $display("[TB] FAIL flash_start got=%0d want=0", pulses); end
    en = 1'b1;
    stepTo(1);
    checks++; if (light !== 8'hFF || phase !== 2'd3) begin failures++; $display("[TB] FAIL flash_exit got=%h/%0d want=ff/3", light, phase); end
    stepTo(3);
    checks++; if (light !== 8'hFD || phase !== 2'd0 || start !== 1'b1) begin failures++; $display("[TB] FAIL flash_resume got=%h/%0d/%b want=fd/0/1", light, phase, start); end
  endtask

  task automatic test_reset_yellow();
    doReset();
    stepTo(4);
    dem = 4'b0010;
    stepTo(1);
    dem = '0;
    stepTo(7);
    checks++; if (light !== 8'hFE) begin failures++; $display("[TB] FAIL ry_yellow got=%h want=fe", light); end
    dem = 4'b0100;
    stepTo(1);
    dem = '0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (light !== 8'hFF || phase !== 2'd3) begin failures++; $display("[TB] FAIL ry_async got=%h/%0d want=ff/3", light, phase); end
    stepTo(2);
    rst = 1'b0;
    stepTo(3);
    checks++; if (light !== 8'hFF) begin failures++; $display("[TB] FAIL ry_clear got=%h want=ff", light); end
    stepTo(1);
    checks++; if (light !== 8'hFD || phase !== 2'd0) begin failures++; $display("[TB] FAIL ry_restart got=%h/%0d want=fd/0", light, phase); end
  endtask

  task automatic test_random();
    doReset();
    for (int c = 0; c < 1500 && failures < 10; c++) begin
      if ($urandom_range(0, 9) == 0) dem = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 149) == 0) en = !en;
      stepTo(1);
      checks++; if (light !== mLight) begin failures++; $display("[TB] FAIL rand_light c=%0d got=%h want=%h", c, light, mLight); end
      checks++; if (phase !== 2'(mPh)) begin failures++; $display("[TB] FAIL rand_phase c=%0d got=%0d want=%0d", c, phase, mPh); end
      checks++; if (start !== mStart) begin failures++; $display("[TB] FAIL rand_start c=%0d got=%b want=%b", c, start, mStart); end
    end
    en = 1'b1;
    dem = '0;
  endtask

  initial begin
    test_reset();
    test_first_green();
    test_skip_empty();
    test_green_max();
    test_rotation();
    test_flash();
    test_reset_yellow();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
